// File: rtl/paddle_pkg.sv
// Shared types and sizing helpers for the paddle pot scheduler.
package paddle_pkg;

   localparam int NUM_PADDLES_DEF = 4;
   localparam int POS_W_DEF       = 7;

   typedef enum logic [1:0] {
      ST_DUMPED   = 2'd0,
      ST_CHARGING = 2'd1,
      ST_DONE     = 2'd2
   } state_t;

   // One spare bit above the largest threshold so saturation sits beyond any reachable compare.
   function automatic int cnt_width(input int pos_w, input int shift);
      return pos_w + shift + 1;
   endfunction

endpackage

// File: rtl/paddle_pot_sched_if.sv
// Paddle pot bus: dump/line_tick/positions in, pot bits and busy out.
interface paddle_pot_sched_if
   import paddle_pkg::*;
#(
   parameter int NUM_PADDLES = NUM_PADDLES_DEF,
   parameter int POS_W       = POS_W_DEF
);
   logic                         dump;
   logic                         line_tick;
   logic [NUM_PADDLES*POS_W-1:0] pos;
   logic [NUM_PADDLES-1:0]       pot;
   logic                         busy;

   modport master (output dump, output line_tick, output pos, input pot, input busy);
   modport slave  (input dump, input line_tick, input pos, output pot, output busy);
endinterface

// File: rtl/pot_channel.sv
// One paddle channel: threshold snapshot and registered line-count compare.
module pot_channel
   import paddle_pkg::*;
#(
   parameter int POS_W = POS_W_DEF,
   parameter int SHIFT = 1,
   parameter int CNT_W = cnt_width(POS_W, SHIFT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             snap_i,
   input  logic             clear_i,
   input  logic             cmp_en_i,
   input  logic [POS_W-1:0] pos_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             pot_o
);

   logic [CNT_W-1:0] thr_q;
   logic [CNT_W-1:0] thr_d;
   logic             pot_q;

   assign thr_d = CNT_W'(pos_i) << SHIFT;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         thr_q <= '0;
         pot_q <= 1'b0;
      end else begin
         if (snap_i) begin
            thr_q <= thr_d;
         end
         if (clear_i) begin
            pot_q <= 1'b0;
         end else if (cmp_en_i) begin
            pot_q <= (cnt_i >= thr_q);
         end
      end
   end

   assign pot_o = pot_q;

endmodule

// File: rtl/paddle_pot_sched.sv
// Paddle pot charge scheduler: dump/charge/done FSM driving per-channel line-count compares.
// Optional PADDLE_DUMP_SYNC_EN inserts a 2-flop synchronizer on dump (adds 2 clk to dump-driven transitions).
module paddle_pot_sched
   import paddle_pkg::*;
#(
   parameter int NUM_PADDLES = NUM_PADDLES_DEF,
   parameter int POS_W       = POS_W_DEF,
   parameter int SHIFT       = 1
) (
   input  logic              clk,
   input  logic              reset,
   paddle_pot_sched_if.slave bus
);

   localparam int CNT_W = cnt_width(POS_W, SHIFT);

   logic dump_s;

`ifdef PADDLE_DUMP_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], bus.dump};
      end
   end

   assign dump_s = sync_q[1];
`else
   assign dump_s = bus.dump;
`endif

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   busy_q;
   logic [NUM_PADDLES-1:0] pot_w;
   logic                   snap;
   logic                   clear;
   logic                   cmp_en;

   assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   assign snap   = (state_q == ST_DUMPED) && !dump_s;
   // A dump abort clears pot on the same edge the FSM drops back to DUMPED.
   assign clear  = dump_s || (state_q == ST_DUMPED);
   assign cmp_en = (state_q != ST_DUMPED);

   for (genvar gi = 0; gi < NUM_PADDLES; gi++) begin : g_ch
      pot_channel #(
         .POS_W (POS_W),
         .SHIFT (SHIFT),
         .CNT_W (CNT_W)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .snap_i   (snap),
         .clear_i  (clear),
         .cmp_en_i (cmp_en),
         .pos_i    (bus.pos[gi*POS_W +: POS_W]),
         .cnt_i    (cnt_q),
         .pot_o    (pot_w[gi])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_DUMPED;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (dump_s) begin
         state_q <= ST_DUMPED;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_DUMPED: begin
               state_q <= ST_CHARGING;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
            ST_CHARGING: begin
               if (&pot_w) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
               end else if (bus.line_tick) begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DONE: begin
               state_q <= ST_DONE;
            end
            default: begin
               state_q <= ST_DUMPED;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pot  = pot_w;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_paddle_pot_sched.sv
// Directed + randomized bench for paddle_pot_sched against a line-count reference model.
module tb_paddle_pot_sched;

   localparam int N    = 4;
   localparam int PW   = 7;
   localparam int SH   = 1;
   localparam int CMAX = (1 << (PW + SH + 1)) - 1;
`ifdef PADDLE_DUMP_SYNC_EN
   localparam int DLY = 2;
`else
   localparam int DLY = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   paddle_pot_sched_if #(.NUM_PADDLES(N), .POS_W(PW)) bus ();

   paddle_pot_sched #(.NUM_PADDLES(N), .POS_W(PW), .SHIFT(SH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: "lines charged since the caps were released" vs. each snapshot threshold.
   bit         m_on;
   bit         m_busy;
   int         m_lines;
   int         m_thr [N];
   bit [N-1:0] m_pot;
   bit         dq [$];

   int rise [N];
   int ticks_issued;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_on = 0; m_busy = 0; m_lines = 0; m_pot = '0;
      for (int i = 0; i < N; i++) m_thr[i] = 0;
      dq.delete();
      for (int i = 0; i < DLY; i++) dq.push_back(1'b0);
   endtask

   task automatic model_edge();
      bit         d;
      bit [N-1:0] np;
      if (DLY == 0) d = bus.dump;
      else begin
         d = dq.pop_front();
         dq.push_back(bus.dump);
      end
      np = '0;
      if (!d && m_on)
         for (int i = 0; i < N; i++) np[i] = (m_lines >= m_thr[i]);
      if (d) begin
         m_on = 0; m_busy = 0; m_lines = 0;
      end else if (!m_on) begin
         m_on = 1; m_busy = 1; m_lines = 0;
         for (int i = 0; i < N; i++) m_thr[i] = int'(bus.pos[i*PW +: PW]) << SH;
      end else if (m_busy) begin
         if (m_pot == '1) m_busy = 0;
         else if (bus.line_tick) m_lines = (m_lines + 1 > CMAX) ? CMAX : m_lines + 1;
      end
      m_pot = np;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("pot", bus.pot, m_pot);
      chk("busy", bus.busy, m_busy);
      for (int i = 0; i < N; i++)
         if (bus.pot[i] && rise[i] < 0) rise[i] = ticks_issued;
   endtask

   task automatic clear_rise();
      for (int i = 0; i < N; i++) rise[i] = -1;
      ticks_issued = 0;
   endtask

   task automatic tick_lines(input int n);
      for (int t = 0; t < n; t++) begin
         bus.line_tick = 1'b1;
         ticks_issued++;
         step();
         bus.line_tick = 1'b0;
         step();
      end
   endtask

   task automatic start_charge(input logic [N*PW-1:0] p);
      bus.dump = 1'b1;
      repeat (DLY + 2) step();
      bus.pos  = p;
      clear_rise();
      bus.dump = 1'b0;
      repeat (DLY + 2) step();
   endtask

   initial begin
      reset = 1'b1;
      bus.dump = 1'b0;
      bus.line_tick = 1'b0;
      bus.pos = {7'd127, 7'd64, 7'd10, 7'd0};
      model_reset();
      clear_rise();
      repeat (3) @(negedge clk);
      chk("reset_pot", bus.pot, 4'h0);
      chk("reset_busy", bus.busy, 1'b0);
      reset = 1'b0;
      step();
      chk("release_busy", bus.busy, 1'b1);

      // Full charge, with a late position change on channel 1, then a long DONE hold.
      start_charge({7'd127, 7'd64, 7'd10, 7'd0});
      chk("entry_pot0", bus.pot[0], 1'b1);
      tick_lines(5);
      bus.pos[1*PW +: PW] = 7'd100;
      tick_lines(254 - 5);
      chk("rise0", rise[0], 0);
      chk("rise1", rise[1], 20);
      chk("rise2", rise[2], 128);
      chk("rise3", rise[3], 254);
      step();
      chk("done_busy", bus.busy, 1'b0);
      tick_lines(300);
      chk("done_hold_pot", bus.pot, 4'hF);

      // Mid-charge abort, then a fresh snapshot counts from zero.
      start_charge({7'd120, 7'd110, 7'd100, 7'd90});
      tick_lines(50);
      bus.dump = 1'b1;
      repeat (DLY + 1) step();
      chk("abort_pot", bus.pot, 4'h0);
      chk("abort_busy", bus.busy, 1'b0);
      start_charge({7'd30, 7'd20, 7'd5, 7'd3});
      tick_lines(70);
      chk("restart_rise0", rise[0], 6);
      chk("restart_rise1", rise[1], 10);
      chk("restart_rise2", rise[2], 40);
      chk("restart_rise3", rise[3], 60);

      // Ticks coincident with dump are discarded.
      bus.line_tick = 1'b1;
      bus.dump = 1'b1;
      repeat (DLY + 2) step();
      bus.line_tick = 1'b0;
      bus.pos = {7'd3, 7'd3, 7'd3, 7'd3};
      clear_rise();
      bus.dump = 1'b0;
      repeat (DLY + 2) step();
      tick_lines(10);
      for (int i = 0; i < N; i++) chk($sformatf("dumptick_rise%0d", i), rise[i], 6);

      // Randomized dump pulses, ticks and positions.
      for (int c = 0; c < 3000; c++) begin
         bus.dump = ($urandom_range(0, 199) < 3);
         bus.line_tick = $urandom_range(0, 1);
         for (int i = 0; i < N; i++) bus.pos[i*PW +: PW] = PW'($urandom_range(0, 24));
         step();
      end

      // Asynchronous reset in mid-charge, released while dump is held high.
      start_charge({7'd90, 7'd80, 7'd70, 7'd60});
      tick_lines(5);
      bus.dump = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("async_pot", bus.pot, 4'h0);
      chk("async_busy", bus.busy, 1'b0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (6) step();
      chk("held_dump_busy", bus.busy, 1'b0);
      bus.dump = 1'b0;
      repeat (DLY + 2) step();
      tick_lines(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
